// File: rtl/ej32_pkg.sv
// eJ32 shared types for the memory arbiter.
// Sizes, arbiter states, grant ids, lane helpers.
package ej32_pkg;

  localparam int AW = 17;

  typedef enum logic [1:0] {
    MS_BYTE,
    MS_HALF,
    MS_WORD
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    ISSUE2,
    CAPT,
    ACK
  } arb_state_t;

  typedef enum logic {
    G_IF,
    G_D
  } grant_t;

  // Size code 3 is an alias of word.
  function automatic mem_size_t to_size(input logic [1:0] s);
    case (s)
      2'd0:    return MS_BYTE;
      2'd1:    return MS_HALF;
      default: return MS_WORD;
    endcase
  endfunction

  // Expand a 4-bit lane mask to a 32-bit bit mask.
  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/ej32_mem_arb_if.sv
// eJ32 requester and mb32 memory bundle.
// slave = arbiter side, master = core/memory side.
interface ej32_mem_arb_if;
  import ej32_pkg::*;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [7:0]    if_data;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic [31:0]   d_rdata;

  logic          mb_we;
  logic [3:0]    mb_bmsk;
  logic [14:0]   mb_ai;
  logic [31:0]   mb_vi;
  logic [31:0]   mb_vo;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_size, d_addr, d_wdata,
    input  mb_vo,
    output if_ack, if_data,
    output d_ack, d_rdata,
    output mb_we, mb_bmsk, mb_ai, mb_vi
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_size, d_addr, d_wdata,
    output mb_vo,
    input  if_ack, if_data,
    input  d_ack, d_rdata,
    input  mb_we, mb_bmsk, mb_ai, mb_vi
  );

endinterface

// File: rtl/ej32_lane_steer.sv
// Big-endian lane steering for one access.
// Masks, beat count and byte shift in an 8-byte window.
module ej32_lane_steer
  import ej32_pkg::*;
(
  input  logic [1:0] off_i,
  input  mem_size_t  size_i,
  output logic [3:0] m1_o,
  output logic [3:0] m2_o,
  output logic       two_o,
  output logic [2:0] sh_o
);

  logic [2:0] n;
  logic [3:0] tot;
  logic [7:0] m8;

  // Item sits at window bytes off..off+n-1; sh is the gap below it.
  always_comb begin
    case (size_i)
      MS_BYTE: n = 3'd1;
      MS_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    tot   = {2'b00, off_i} + {1'b0, n};
    sh_o  = 3'(4'd8 - tot);
    m8    = ((8'd1 << n) - 8'd1) << sh_o;
    two_o = tot > 4'd4;
    m1_o  = m8[7:4];
    m2_o  = m8[3:0];
  end

endmodule

// File: rtl/ej32_mem_arb.sv
// eJ32 fetch/data arbiter and mb32 access sequencer.
// Splits unaligned big-endian accesses into one or two beats.
module ej32_mem_arb
  import ej32_pkg::*;
(
  input logic           clk,
  input logic           rst,
  ej32_mem_arb_if.slave bus
);

  arb_state_t    state_q, state_d;
  grant_t        gnt_q, gnt_sel;
  logic          we_q;
  mem_size_t     size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          cur_we;
  mem_size_t     cur_size;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;

  logic [3:0]    m1, m2;
  logic          two;
  logic [2:0]    sh;
  logic [14:0]   word;
  logic [63:0]   wv;
  logic [31:0]   b1, b2, rdata;

  logic          mb_we_q, mb_we_d;
  logic [3:0]    bmsk_q, bmsk_d;
  logic [14:0]   ai_q, ai_d;
  logic [31:0]   vi_q, vi_d;
  logic [31:0]   rd1_q;
  logic [7:0]    if_data_q;
  logic [31:0]   d_rdata_q;

  // Grant choice in IDLE; gnt_q doubles as last-grant.
  always_comb begin
    gnt_sel = G_IF;
    if (bus.if_req && bus.d_req)
      gnt_sel = (gnt_q == G_IF) ? G_D : G_IF;
    else if (bus.d_req)
      gnt_sel = G_D;
  end

  // Live grantee fields in IDLE, latched fields afterwards.
  always_comb begin
    cur_we    = we_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_wdata = bus.d_wdata;
      if (gnt_sel == G_D) begin
        cur_we   = bus.d_we;
        cur_size = to_size(bus.d_size);
        cur_addr = bus.d_addr;
      end else begin
        cur_we   = 1'b0;
        cur_size = MS_BYTE;
        cur_addr = bus.if_addr;
      end
    end
  end

  ej32_lane_steer u_steer (
    .off_i  (cur_addr[1:0]),
    .size_i (cur_size),
    .m1_o   (m1),
    .m2_o   (m2),
    .two_o  (two),
    .sh_o   (sh)
  );

  assign word  = cur_addr[AW-1:2];
  assign wv    = {32'd0, cur_wdata} << {sh, 3'b000};
  assign b1    = two ? rd1_q : bus.mb_vo;
  assign b2    = two ? bus.mb_vo : 32'd0;
  assign rdata = 32'({b1 & lanes(m1), b2 & lanes(m2)}
                     >> {sh, 3'b000});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.if_req || bus.d_req) state_d = ISSUE1;
      ISSUE1:  state_d = two ? ISSUE2 : (cur_we ? ACK : CAPT);
      ISSUE2:  state_d = cur_we ? ACK : CAPT;
      CAPT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the transaction on IDLE exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= G_IF;
      we_q    <= 1'b0;
      size_q  <= MS_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && state_d == ISSUE1) begin
      gnt_q   <= gnt_sel;
      we_q    <= cur_we;
      size_q  <= cur_size;
      addr_q  <= cur_addr;
      wdata_q <= cur_wdata;
    end
  end

  // Memory port values for the coming cycle.
  always_comb begin
    mb_we_d = 1'b0;
    bmsk_d  = 4'd0;
    ai_d    = ai_q;
    vi_d    = vi_q;
    unique case (state_d)
      ISSUE1: begin
        mb_we_d = cur_we;
        bmsk_d  = m1;
        ai_d    = word;
        vi_d    = wv[63:32];
      end
      ISSUE2: begin
        mb_we_d = cur_we;
        bmsk_d  = m2;
        ai_d    = word + 15'd1;
        vi_d    = wv[31:0];
      end
      default: ;
    endcase
  end

  // Registered memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_we_q <= 1'b0;
      bmsk_q  <= 4'd0;
      ai_q    <= 15'd0;
      vi_q    <= 32'd0;
    end else begin
      mb_we_q <= mb_we_d;
      bmsk_q  <= bmsk_d;
      ai_q    <= ai_d;
      vi_q    <= vi_d;
    end
  end

  // Read capture: beat 1 held over ISSUE2, result built in CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q     <= 32'd0;
      if_data_q <= 8'd0;
      d_rdata_q <= 32'd0;
    end else begin
      if (state_q == ISSUE2) rd1_q <= bus.mb_vo;
      if (state_q == CAPT) begin
        if (gnt_q == G_IF) if_data_q <= rdata[7:0];
        else               d_rdata_q <= rdata;
      end
    end
  end

  assign bus.mb_we   = mb_we_q;
  assign bus.mb_bmsk = bmsk_q;
  assign bus.mb_ai   = ai_q;
  assign bus.mb_vi   = vi_q;
  assign bus.if_ack  = (state_q == ACK) && (gnt_q == G_IF);
  assign bus.d_ack   = (state_q == ACK) && (gnt_q == G_D);
  assign bus.if_data = if_data_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Bench for ej32_mem_arb: directed cases, then random traffic
// checked against a byte-addressed big-endian reference memory.
module tb_ej32_mem_arb;
  import ej32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem  [0:32767];
  logic [7:0]  refm [0:131071];

  ej32_mem_arb_if bus ();

  ej32_mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mb_we)
      for (int l = 0; l < 4; l++)
        if (bus.mb_bmsk[l]) mem[bus.mb_ai][8*l +: 8] <= bus.mb_vi[8*l +: 8];
    bus.mb_vo <= mem[bus.mb_ai];
  end

  function automatic logic [31:0] lmask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) if (m[l]) r[8*l +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic setword(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) refm[4*w + k] = v[31-8*k -: 8];
  endtask

  function automatic logic [31:0] refword(input int w);
    return {refm[4*w], refm[4*w+1], refm[4*w+2], refm[4*w+3]};
  endfunction

  // One request on one port, from IDLE, with beat and latency checks.
  task automatic txn(input bit f, input bit we, input logic [1:0] sz,
                     input logic [16:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n, lat, cnt;
    logic [3:0] m1, m2;
    logic [31:0] v1, v2, exp_rd;
    logic [14:0] w1, w2;
    logic [16:0] b;
    logic [7:0] byt;
    bit two, ack, oth;
    if (f) we = 1'b0;
    n = f ? 1 : (sz == 2'd0 ? 1 : (sz == 2'd1 ? 2 : 4));
    m1 = '0; m2 = '0; v1 = '0; v2 = '0; exp_rd = '0; rd = '0;
    w1 = a[16:2];
    w2 = w1 + 15'd1;
    for (int i = 0; i < n; i++) begin
      b   = a + 17'(i);
      byt = wd[8*(n-1-i) +: 8];
      if (b[16:2] == w1) begin
        m1[3 - b[1:0]] = 1'b1;
        v1[8*(3 - b[1:0]) +: 8] = byt;
      end else begin
        m2[3 - b[1:0]] = 1'b1;
        v2[8*(3 - b[1:0]) +: 8] = byt;
      end
      if (we) refm[b] = byt;
      else    exp_rd = {exp_rd[23:0], refm[b]};
    end
    two = (m2 != 4'd0);
    lat = we ? (two ? 3 : 2) : (two ? 4 : 3);
    if (f) begin
      bus.if_addr = a;
      bus.if_req  = 1'b1;
    end else begin
      bus.d_we    = we;
      bus.d_size  = sz;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
    end
    cnt = 0;
    ack = 1'b0;
    oth = 1'b0;
    while (cnt < 12 && !ack) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        chk("b1_ai", 64'(bus.mb_ai), 64'(w1));
        chk("b1_msk", 64'(bus.mb_bmsk), 64'(m1));
        chk("b1_we", 64'(bus.mb_we), 64'(we));
        if (we) chk("b1_vi", 64'(bus.mb_vi & lmask(m1)), 64'(v1));
      end
      if (cnt == 2) begin
        if (two) begin
          chk("b2_ai", 64'(bus.mb_ai), 64'(w2));
          chk("b2_msk", 64'(bus.mb_bmsk), 64'(m2));
          chk("b2_we", 64'(bus.mb_we), 64'(we));
          if (we) chk("b2_vi", 64'(bus.mb_vi & lmask(m2)), 64'(v2));
        end else begin
          chk("idle_msk", 64'(bus.mb_bmsk), 64'd0);
          chk("idle_we", 64'(bus.mb_we), 64'd0);
        end
      end
      ack = f ? bus.if_ack : bus.d_ack;
      oth = f ? bus.d_ack : bus.if_ack;
    end
    chk("latency", 64'(cnt), 64'(lat));
    chk("other_ack", 64'(oth), 64'd0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    if (!we) begin
      rd = f ? {24'd0, bus.if_data} : bus.d_rdata;
      chk(f ? "if_data" : "d_rdata", 64'(rd), 64'(exp_rd));
    end
    @(posedge clk); #1;
    chk("ack_pulse", 64'(bus.if_ack | bus.d_ack), 64'd0);
  endtask

  initial begin
    logic [31:0] rd, wd, dexp;
    logic [16:0] a;
    logic [1:0]  sz;
    logic [7:0]  iexp;
    bit f, we, exp_d, prev;
    int nack;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0;
    bus.d_addr = '0; bus.d_wdata = '0;
    for (int w = 0; w < 32768; w++) setword(w, $urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 64'(bus.mb_we), 64'd0);
    chk("rst_msk", 64'(bus.mb_bmsk), 64'd0);
    chk("rst_ai", 64'(bus.mb_ai), 64'd0);
    chk("rst_vi", 64'(bus.mb_vi), 64'd0);
    chk("rst_acks", 64'({bus.if_ack, bus.d_ack}), 64'd0);
    chk("rst_ifd", 64'(bus.if_data), 64'd0);
    chk("rst_drd", 64'(bus.d_rdata), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    setword(1, 32'h11223344);
    txn(1'b0, 1'b0, 2'd2, 17'h00004, 32'd0, rd);
    chk("ld_word", 64'(rd), 64'h11223344);

    setword(1, 32'hAABBCCDD);
    txn(1'b1, 1'b0, 2'd0, 17'h00007, 32'd0, rd);
    chk("fetch_dd", 64'(rd), 64'hDD);

    txn(1'b0, 1'b1, 2'd2, 17'h00002, 32'h11223344, rd);
    txn(1'b0, 1'b0, 2'd3, 17'h00002, 32'd0, rd);
    chk("st_ld_back", 64'(rd), 64'h11223344);

    setword(32'h7FFF, 32'h000000EE);
    setword(0, 32'hFF000000);
    txn(1'b0, 1'b0, 2'd1, 17'h1FFFF, 32'd0, rd);
    chk("half_wrap", 64'(rd), 64'h0000EEFF);

    // Reset during beat 1 of a two-beat store.
    wd = $urandom;
    bus.d_we = 1'b1; bus.d_size = 2'd2;
    bus.d_addr = 17'h00011; bus.d_wdata = wd; bus.d_req = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_we", 64'(bus.mb_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_we", 64'(bus.mb_we), 64'd0);
    chk("rst_mid_msk", 64'(bus.mb_bmsk), 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_ack", 64'(bus.d_ack), 64'd0);
    rst = 1'b0;
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    txn(1'b0, 1'b1, 2'd2, 17'h00011, wd, rd);
    chk("rst_reissue", 64'(mem[4]), 64'(refword(4)));

    // Both requests held from reset: data first, then alternate.
    rst = 1'b1;
    bus.if_addr = 17'h00005; bus.if_req = 1'b1;
    bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 17'h00008;
    bus.d_req = 1'b1;
    iexp = refm[5];
    dexp = refword(2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nack = 0; exp_d = 1'b1; prev = 1'b0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(posedge clk); #1;
      if (bus.if_ack || bus.d_ack) begin
        chk("tie_d", 64'(bus.d_ack), 64'(exp_d));
        chk("tie_if", 64'(bus.if_ack), 64'(!exp_d));
        chk("tie_pulse", 64'(prev), 64'd0);
        if (exp_d) chk("tie_drd", 64'(bus.d_rdata), 64'(dexp));
        else       chk("tie_ifd", 64'(bus.if_data), 64'(iexp));
        exp_d = !exp_d;
        nack++;
        prev = 1'b1;
      end else prev = 1'b0;
    end
    chk("tie_count", 64'(nack), 64'd4);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    for (int t = 0; t < 60; t++) begin
      f  = ($urandom_range(0, 3) == 0);
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = 17'h1FFF8 + 17'($urandom_range(0, 7));
      else                           a = 17'($urandom_range(0, 47));
      wd = $urandom;
      txn(f, we, sz, a, wd, rd);
    end

    for (int w = 0; w < 14; w++) chk("mem_lo", 64'(mem[w]), 64'(refword(w)));
    for (int w = 32766; w < 32768; w++)
      chk("mem_hi", 64'(mem[w]), 64'(refword(w)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
